psc_tile_sequencer: RTL and testbench

PSC_TILE_SEQUENCER -- requirements
Module: psc_tile_sequencer

---
 rtl/psc_ctrl_pkg.sv | 18 +
 rtl/psc_watchdog.sv | 35 +++
 rtl/psc_tile_sequencer.sv | 151 +++++++++++++++
 tb/tb_psc_tile_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psc_ctrl_pkg.sv
// Shared definitions for the PSC tile sequencer.
// Holds the sequencer FSM state encoding and the converter-array mode encodings.
package psc_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLaunch = 3'd1,
    StWait   = 3'd2,
    StGap    = 3'd3,
    StDone   = 3'd4
  } psc_state_e;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_S2P  = 2'b01;
  localparam logic [1:0] MODE_P2S  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

endpackage

// File: rtl/psc_watchdog.sv
// Per-pass watchdog for the PSC tile sequencer.
// Counts enabled cycles from a clear and flags the terminal count.
//   clk        : clock
//   reset      : asynchronous active-high reset
//   i_clear    : return the count to zero (priority over enable)
//   i_enable   : advance the count by one this cycle
//   o_expired  : count has reached TIMEOUT_CYCLES-1
module psc_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [15:0] TermCnt = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_count;

  // Saturates at the terminal count so a stalled enable can never wrap to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_expired = (r_count == TermCnt);

endmodule

// File: rtl/psc_tile_sequencer.sv
// PSC tile sequencer.
// Accepts a (mode, pass count) command from the host, then issues one start pulse per pass to
// the converter array and waits for its finish, with a watchdog bounding each wait. Reports a
// one-cycle done pulse at the end of the command and a sticky timeout error.
//   clk/reset            : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  : command handshake (ready only while idle)
//   cmd_mode/cmd_count   : conversion mode and number of passes
//   psc_mode/psc_start   : mode and start pulse to the converter array
//   psc_finish           : completion from the converter array (level or pulse)
//   busy/pass_idx        : command in progress, 0-based current pass
//   done/error           : command complete pulse, sticky timeout flag
// All outputs are registered.
module psc_tile_sequencer
  import psc_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WORD_LENGTH = 16,
  parameter int unsigned COUNT_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_mode,
  input  logic [COUNT_W-1:0] cmd_count,
  output logic [1:0]         psc_mode,
  output logic               psc_start,
  input  logic               psc_finish,
  output logic               busy,
  output logic [COUNT_W-1:0] pass_idx,
  output logic               done,
  output logic               error
);

  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535) || (MAX_WORD_LENGTH == 0)) begin : g_bad_param
    $error("psc_tile_sequencer: illegal parameter value");
  end

  psc_state_e         r_state;
  psc_state_e         w_state_d;
  logic               r_cmd_ready;
  logic               r_busy;
  logic               r_psc_start;
  logic               r_done;
  logic               r_error;
  logic [1:0]         r_psc_mode;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] r_pass_idx;

  logic w_accept;
  logic w_pass_adv;
  logic w_timeout;
  logic w_last_pass;
  logic w_wd_clear;
  logic w_wd_en;
  logic w_wd_expired;

  assign w_last_pass = (r_pass_idx == (r_count - COUNT_W'(1)));

  psc_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_en),
    .o_expired (w_wd_expired)
  );

  always_comb begin
    w_state_d  = r_state;
    w_accept   = 1'b0;
    w_pass_adv = 1'b0;
    w_timeout  = 1'b0;
    w_wd_clear = 1'b0;
    w_wd_en    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (cmd_valid) begin
          w_accept  = 1'b1;
          w_state_d = (cmd_count != '0) ? StLaunch : StDone;
        end
      end
      // psc_finish is deliberately not looked at here: it may still be high from the last pass.
      StLaunch: begin
        w_wd_clear = 1'b1;
        w_state_d  = StWait;
      end
      StWait: begin
        w_wd_en = 1'b1;
        // Finish is checked first so a finish on the terminal watchdog cycle is not an error.
        if (psc_finish) begin
          if (w_last_pass) begin
            w_state_d = StDone;
          end else begin
            w_pass_adv = 1'b1;
            w_state_d  = StGap;
          end
        end else if (w_wd_expired) begin
          w_timeout = 1'b1;
          w_state_d = StDone;
        end
      end
      StGap:   w_state_d = StLaunch;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_psc_start <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_psc_mode  <= MODE_IDLE;
      r_count     <= '0;
      r_pass_idx  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cmd_ready <= (w_state_d == StIdle);
      r_busy      <= (w_state_d != StIdle);
      r_psc_start <= (w_state_d == StLaunch);
      r_done      <= (w_state_d == StDone);
      if (w_accept) begin
        r_psc_mode <= cmd_mode;
        r_count    <= cmd_count;
        r_pass_idx <= '0;
        r_error    <= 1'b0;
      end
      if (w_pass_adv) begin
        r_pass_idx <= r_pass_idx + COUNT_W'(1);
      end
      if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign psc_start = r_psc_start;
  assign done      = r_done;
  assign error     = r_error;
  assign psc_mode  = r_psc_mode;
  assign pass_idx  = r_pass_idx;

endmodule

// File: tb/tb_psc_tile_sequencer.sv
// Directed self-checking bench for psc_tile_sequencer (TIMEOUT_CYCLES = 8).
// Inputs are driven and outputs sampled on the falling edge; a posedge monitor counts start
// pulses, done pulses and start pulses separated by fewer than two low cycles.
module tb_psc_tile_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_count;
  logic [1:0] psc_mode;
  logic       psc_start;
  logic       psc_finish;
  logic       busy;
  logic [7:0] pass_idx;
  logic       done;
  logic       error;

  int n_checks = 0;
  int n_err    = 0;

  int n_start  = 0;
  int n_done   = 0;
  int bad_gap  = 0;
  int low_run  = 0;
  bit seen_st  = 1'b0;

  int s0;
  int d0;

  psc_tile_sequencer #(
    .MAX_WORD_LENGTH (16),
    .COUNT_W         (8),
    .TIMEOUT_CYCLES  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_count  (cmd_count),
    .psc_mode   (psc_mode),
    .psc_start  (psc_start),
    .psc_finish (psc_finish),
    .busy       (busy),
    .pass_idx   (pass_idx),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done === 1'b1) n_done <= n_done + 1;
    if (psc_start === 1'b1) begin
      if (seen_st && low_run < 2) bad_gap <= bad_gap + 1;
      seen_st <= 1'b1;
      low_run <= 0;
      n_start <= n_start + 1;
    end else begin
      low_run <= low_run + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents one command for a single cycle; returns in the cycle after the accept.
  task automatic issue(input logic [1:0] m, input logic [7:0] c);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_count = c;
    step();
    cmd_valid = 1'b0;
  endtask

  // Entered in the launch cycle of pass idx. Holds a stale finish through launch, then finishes
  // in the second wait cycle. Returns in the next launch cycle, or in the idle cycle after done.
  task automatic run_pass(input int idx, input bit last);
    chk("start_hi", psc_start, 1);
    chk("pass_idx", pass_idx, idx);
    psc_finish = 1'b1;
    step();
    psc_finish = 1'b0;
    chk("start_lo_wait", psc_start, 0);
    step();
    psc_finish = 1'b1;
    step();
    psc_finish = 1'b0;
    if (!last) begin
      chk("start_lo_gap", psc_start, 0);
      chk("pass_adv", pass_idx, idx + 1);
      chk("no_done_mid", done, 0);
      step();
    end else begin
      chk("done_last", done, 1);
      chk("pass_last", pass_idx, idx);
      step();
      chk("ready_after", cmd_ready, 1);
      chk("done_one_cyc", done, 0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_mode   = 2'b00;
    cmd_count  = 8'd0;
    psc_finish = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", psc_start, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_pass", pass_idx, 0);
    chk("rst_mode", psc_mode, 0);

    // Single pass; cmd_valid kept high with other values while busy must be ignored.
    s0 = n_start;
    d0 = n_done;
    cmd_valid = 1'b1;
    cmd_mode  = 2'b01;
    cmd_count = 8'd1;
    step();
    chk("s1_start", psc_start, 1);
    chk("s1_ready", cmd_ready, 0);
    chk("s1_busy", busy, 1);
    chk("s1_mode", psc_mode, 2'b01);
    cmd_mode  = 2'b11;
    cmd_count = 8'd5;
    repeat (5) step();
    cmd_valid  = 1'b0;
    psc_finish = 1'b1;
    chk("s1_no_done_yet", done, 0);
    step();
    psc_finish = 1'b0;
    chk("s1_done", done, 1);
    chk("s1_error", error, 0);
    chk("s1_mode_hold", psc_mode, 2'b01);
    chk("s1_start_lo", psc_start, 0);
    step();
    chk("s1_ready_back", cmd_ready, 1);
    chk("s1_busy_lo", busy, 0);
    chk("s1_done_lo", done, 0);
    chk("s1_n_start", n_start - s0, 1);
    chk("s1_n_done", n_done - d0, 1);

    // Three passes.
    s0 = n_start;
    d0 = n_done;
    issue(2'b10, 8'd3);
    run_pass(0, 1'b0);
    run_pass(1, 1'b0);
    run_pass(2, 1'b1);
    chk("s2_n_start", n_start - s0, 3);
    chk("s2_n_done", n_done - d0, 1);
    chk("s2_gap", bad_gap, 0);
    chk("s2_mode", psc_mode, 2'b10);

    // Timeout: no finish for the whole watchdog window.
    issue(2'b11, 8'd1);
    chk("s3_start", psc_start, 1);
    repeat (8) step();
    chk("s3_not_done", done, 0);
    chk("s3_busy", busy, 1);
    step();
    chk("s3_done", done, 1);
    chk("s3_error", error, 1);
    step();
    chk("s3_ready", cmd_ready, 1);
    chk("s3_error_hold", error, 1);
    chk("s3_mode_idle", psc_mode, 2'b11);

    // Zero-pass command: straight to done, clears the previous error.
    s0 = n_start;
    issue(2'b00, 8'd0);
    chk("s4_done", done, 1);
    chk("s4_no_start", psc_start, 0);
    chk("s4_err_clr", error, 0);
    chk("s4_mode", psc_mode, 2'b00);
    chk("s4_busy", busy, 1);
    step();
    chk("s4_ready", cmd_ready, 1);
    chk("s4_done_lo", done, 0);
    chk("s4_n_start", n_start - s0, 0);

    // Finish on the terminal watchdog cycle.
    issue(2'b01, 8'd1);
    repeat (8) step();
    psc_finish = 1'b1;
    chk("s5_not_done", done, 0);
    step();
    psc_finish = 1'b0;
    chk("s5_done", done, 1);
    chk("s5_error", error, 0);
    step();
    chk("s5_ready", cmd_ready, 1);

    // Asynchronous reset in the wait of the second pass.
    issue(2'b10, 8'd3);
    run_pass(0, 1'b0);
    chk("s6_start2", psc_start, 1);
    step();
    d0 = n_done;
    #2 reset = 1'b1;
    #1;
    chk("s6_start", psc_start, 0);
    chk("s6_busy", busy, 0);
    chk("s6_pass", pass_idx, 0);
    chk("s6_done", done, 0);
    chk("s6_mode", psc_mode, 0);
    chk("s6_ready", cmd_ready, 1);
    step();
    step();
    reset = 1'b0;
    step();
    step();
    chk("s6_no_done", n_done - d0, 0);
    chk("s6_idle", busy, 0);
    issue(2'b01, 8'd2);
    run_pass(0, 1'b0);
    run_pass(1, 1'b1);
    chk("s6_mode_new", psc_mode, 2'b01);

    // Maximum pass count.
    s0 = n_start;
    d0 = n_done;
    issue(2'b10, 8'd255);
    for (int i = 0; i < 255; i++) begin
      run_pass(i, i == 254);
    end
    chk("s7_n_start", n_start - s0, 255);
    chk("s7_n_done", n_done - d0, 1);
    chk("s7_gap", bad_gap, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
